// File: rtl/vga_palette_pkg.sv
// Shared types, widths and the MSB-first field replication helper for the VGA colour stage.
package vga_palette_pkg;

  typedef enum logic [1:0] {
    PAL_TRUE = 2'd0,
    PAL_GRAY = 2'd1,
    PAL_RAM  = 2'd2,
    PAL_RSVD = 2'd3
  } pal_mode_e;

  localparam int CHANNEL_WIDTH = 8;
  localparam int BGR_WIDTH     = 3 * CHANNEL_WIDTH;
  localparam int IDX_W         = $clog2(CHANNEL_WIDTH);

  // Widen a right-aligned field of `width` bits by repeating it MSB-first,
  // so all-ones maps to full scale and zero stays zero.
  function automatic logic [CHANNEL_WIDTH-1:0] replicate_field(
    input int                       width,
    input logic [CHANNEL_WIDTH-1:0] value
  );
    logic [CHANNEL_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < CHANNEL_WIDTH; i++) begin
      r[IDX_W'(CHANNEL_WIDTH - 1 - i)] = value[IDX_W'(width - 1 - (i % width))];
    end
    return r;
  endfunction

endpackage

// File: rtl/vga_palette_ram.sv
// Palette store: one write port, one synchronous read-first read port, no reset on contents.
module vga_palette_ram
  import vga_palette_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = BGR_WIDTH
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rd_data_q;

  // Read and write share one edge; the read sees the pre-write contents.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/vga_rgb_palette_pipeline.sv
// Two-stage pixel-to-BGR colour mapper (true-colour, grayscale, palette) with aligned sync sideband.
// Palette RAM and mode 2 are built only when VGA_PALETTE_RAM_EN is defined.
module vga_rgb_palette_pipeline
  import vga_palette_pkg::pal_mode_e;
  import vga_palette_pkg::PAL_TRUE;
  import vga_palette_pkg::PAL_GRAY;
  import vga_palette_pkg::PAL_RAM;
  import vga_palette_pkg::replicate_field;
#(
  parameter int PIXEL_WIDTH   = 8,
  parameter int RED_BITS      = 3,
  parameter int GREEN_BITS    = 3,
  parameter int BLUE_BITS     = 2,
  parameter int CHANNEL_WIDTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [1:0]                 mode,
  input  logic                       in_valid,
  input  logic [PIXEL_WIDTH-1:0]     in_pixel,
  input  logic                       in_hsync,
  input  logic                       in_vsync,
  input  logic                       in_blank,
  input  logic                       wr_en,
  input  logic [PIXEL_WIDTH-1:0]     wr_addr,
  input  logic [3*CHANNEL_WIDTH-1:0] wr_data,
  output logic [3*CHANNEL_WIDTH-1:0] q,
  output logic                       out_valid,
  output logic                       out_hsync,
  output logic                       out_vsync,
  output logic                       out_blank,
  output logic [1:0]                 mode_act
);

  localparam int PW = PIXEL_WIDTH;
  localparam int CW = CHANNEL_WIDTH;
  localparam int QW = 3 * CHANNEL_WIDTH;

  pal_mode_e       mode_act_q, mode_act_d;
  logic [PW-1:0]   pix_p1_q, pix_p1_d;
  logic            vld_p1_q, vld_p1_d, hs_p1_q, hs_p1_d, vs_p1_q, vs_p1_d, blk_p1_q, blk_p1_d;
  logic [QW-1:0]   colour_p2_q, colour_p2_d;
  logic            vld_p2_q, vld_p2_d, hs_p2_q, hs_p2_d, vs_p2_q, vs_p2_d, blk_p2_q, blk_p2_d;
  logic [CW-1:0]   tc_r, tc_g, tc_b, gray;
  logic [QW-1:0]   colour;

`ifdef VGA_PALETTE_RAM_EN
  logic [QW-1:0]   ram_rd;

  vga_palette_ram #(
    .ADDR_W (PW),
    .DATA_W (QW)
  ) u_ram (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (in_pixel),
    .rd_data (ram_rd)
  );
`else
  logic unused_wr;
  assign unused_wr = ^{wr_en, wr_addr, wr_data};
`endif

  always_comb begin
    // vs_p1_q doubles as the vsync history used for rising-edge detection.
    mode_act_d = mode_act_q;
    if (in_vsync && !vs_p1_q) mode_act_d = pal_mode_e'(mode);

    pix_p1_d = in_pixel;
    vld_p1_d = in_valid;
    hs_p1_d  = in_hsync;
    vs_p1_d  = in_vsync;
    blk_p1_d = in_blank;

    tc_r = replicate_field(RED_BITS,   CW'(pix_p1_q[PW-1 -: RED_BITS]));
    tc_g = replicate_field(GREEN_BITS, CW'(pix_p1_q[PW-1-RED_BITS -: GREEN_BITS]));
    tc_b = replicate_field(BLUE_BITS,  CW'(pix_p1_q[BLUE_BITS-1:0]));
    gray = replicate_field(PW,         CW'(pix_p1_q));

    case (mode_act_q)
      PAL_GRAY: colour = {gray, gray, gray};
`ifdef VGA_PALETTE_RAM_EN
      PAL_RAM:  colour = ram_rd;
`endif
      default:  colour = {tc_b, tc_g, tc_r};
    endcase

    colour_p2_d = (vld_p1_q && !blk_p1_q) ? colour : '0;
    vld_p2_d    = vld_p1_q;
    hs_p2_d     = hs_p1_q;
    vs_p2_d     = vs_p1_q;
    blk_p2_d    = blk_p1_q;
  end

  // Stage 1: pixel capture (data only, no reset needed)
  always_ff @(posedge clock) begin
    pix_p1_q <= pix_p1_d;
  end

  // Stage 1 sideband / stage 2 colour and sideband, plus mode register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mode_act_q  <= PAL_TRUE;
      vld_p1_q    <= 1'b0;
      hs_p1_q     <= 1'b0;
      vs_p1_q     <= 1'b0;
      blk_p1_q    <= 1'b0;
      colour_p2_q <= '0;
      vld_p2_q    <= 1'b0;
      hs_p2_q     <= 1'b0;
      vs_p2_q     <= 1'b0;
      blk_p2_q    <= 1'b0;
    end else begin
      mode_act_q  <= mode_act_d;
      vld_p1_q    <= vld_p1_d;
      hs_p1_q     <= hs_p1_d;
      vs_p1_q     <= vs_p1_d;
      blk_p1_q    <= blk_p1_d;
      colour_p2_q <= colour_p2_d;
      vld_p2_q    <= vld_p2_d;
      hs_p2_q     <= hs_p2_d;
      vs_p2_q     <= vs_p2_d;
      blk_p2_q    <= blk_p2_d;
    end
  end

  assign q         = colour_p2_q;
  assign out_valid = vld_p2_q;
  assign out_hsync = hs_p2_q;
  assign out_vsync = vs_p2_q;
  assign out_blank = blk_p2_q;
  assign mode_act  = mode_act_q;

endmodule

// File: tb/tb_vga_rgb_palette_pipeline.sv
// Directed bench for the VGA colour stage: reset, true-colour, grayscale, blanking, mode timing, palette.
module tb_vga_rgb_palette_pipeline;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  mode;
  logic        in_valid;
  logic [7:0]  in_pixel;
  logic        in_hsync, in_vsync, in_blank;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [23:0] wr_data;
  logic [23:0] q;
  logic        out_valid, out_hsync, out_vsync, out_blank;
  logic [1:0]  mode_act;

  int checks = 0;
  int errors = 0;

  vga_rgb_palette_pipeline dut (
    .clock     (clock),
    .reset     (reset),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_pixel  (in_pixel),
    .in_hsync  (in_hsync),
    .in_vsync  (in_vsync),
    .in_blank  (in_blank),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .q         (q),
    .out_valid (out_valid),
    .out_hsync (out_hsync),
    .out_vsync (out_vsync),
    .out_blank (out_blank),
    .mode_act  (mode_act)
  );

  always #5 clock = ~clock;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Pulse vsync to make `m` the active mode.
  task automatic set_mode(input logic [1:0] m);
    mode = m;
    in_vsync = 1'b1;
    step();
    in_vsync = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; mode = 2'd0; in_valid = 1'b0; in_pixel = 8'h00;
    in_hsync = 1'b0; in_vsync = 1'b0; in_blank = 1'b0;
    wr_en = 1'b0; wr_addr = 8'h00; wr_data = 24'h0;
    step(); step();
    checks++;
    if ({q, out_valid, out_hsync, out_vsync, out_blank, mode_act} !== 30'h0) begin
      errors++;
      $display("FAIL reset_state: got q=%h v=%b h=%b vs=%b b=%b m=%0d, want all zero",
               q, out_valid, out_hsync, out_vsync, out_blank, mode_act);
    end
    reset = 1'b0; in_valid = 1'b1; in_pixel = 8'h12; in_hsync = 1'b1;
    step(); step();
    checks++;
    if (q !== 24'hAA9200 || out_valid !== 1'b1 || out_hsync !== 1'b1) begin
      errors++;
      $display("FAIL stream_pre_reset: got q=%h v=%b h=%b, want q=aa9200 v=1 h=1", q, out_valid, out_hsync);
    end
    in_pixel = 8'hFF;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (q !== 24'h0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_clear: got q=%h v=%b, want q=000000 v=0", q, out_valid);
    end
    step();
    reset = 1'b0;
    checks++;
    if (q !== 24'h0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_release_cycle1: got q=%h v=%b, want q=000000 v=0", q, out_valid);
    end
    step();
    checks++;
    if (q !== 24'h0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_release_cycle2: got q=%h v=%b, want q=000000 v=0", q, out_valid);
    end
    step();
    checks++;
    if (q !== 24'hFFFFFF || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL post_release_full_scale: got q=%h v=%b, want q=ffffff v=1", q, out_valid);
    end
  endtask

  task automatic test_true_colour();
    in_pixel = 8'b101_011_01;
    step();
    checks++;
    if (q !== 24'hFFFFFF) begin
      errors++;
      $display("FAIL true_colour_latency1: got q=%h, want q=ffffff (old pixel)", q);
    end
    step();
    checks++;
    if (q !== 24'h556DB6 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL true_colour_fields: got q=%h v=%b, want q=556db6 v=1", q, out_valid);
    end
    in_pixel = 8'h00;
    step(); step();
    checks++;
    if (q !== 24'h000000) begin
      errors++;
      $display("FAIL true_colour_zero: got q=%h, want q=000000", q);
    end
  endtask

  task automatic test_grayscale_blank();
    set_mode(2'd1);
    checks++;
    if (mode_act !== 2'd1) begin
      errors++;
      $display("FAIL gray_mode_act: got %0d, want 1", mode_act);
    end
    in_pixel = 8'h3C; in_blank = 1'b0;
    step(); step();
    checks++;
    if (q !== 24'h3C3C3C || out_blank !== 1'b0) begin
      errors++;
      $display("FAIL gray_value: got q=%h b=%b, want q=3c3c3c b=0", q, out_blank);
    end
    in_blank = 1'b1;
    step(); step();
    checks++;
    if (q !== 24'h0 || out_blank !== 1'b1) begin
      errors++;
      $display("FAIL gray_blanked: got q=%h b=%b, want q=000000 b=1", q, out_blank);
    end
    in_blank = 1'b0; in_valid = 1'b0; in_pixel = 8'hFF;
    step(); step();
    checks++;
    if (q !== 24'h0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL invalid_forces_zero: got q=%h v=%b, want q=000000 v=0", q, out_valid);
    end
    in_valid = 1'b1;
  endtask

  task automatic test_mode_switch();
    set_mode(2'd0);
    checks++;
    if (mode_act !== 2'd0) begin
      errors++;
      $display("FAIL mode_back_to_0: got %0d, want 0", mode_act);
    end
    mode = 2'd1;
    step(); step(); step();
    checks++;
    if (mode_act !== 2'd0) begin
      errors++;
      $display("FAIL mode_held_mid_frame: got %0d, want 0", mode_act);
    end
    in_vsync = 1'b1;
    #1;
    checks++;
    if (mode_act !== 2'd0) begin
      errors++;
      $display("FAIL mode_before_edge: got %0d, want 0", mode_act);
    end
    step();
    checks++;
    if (mode_act !== 2'd1 || out_vsync !== 1'b0) begin
      errors++;
      $display("FAIL mode_after_vsync: got m=%0d vs=%b, want m=1 vs=0", mode_act, out_vsync);
    end
    in_vsync = 1'b0;
    step();
    checks++;
    if (out_vsync !== 1'b1) begin
      errors++;
      $display("FAIL vsync_alignment: got vs=%b, want 1", out_vsync);
    end
    mode = 2'd3;
    in_vsync = 1'b1;
    step();
    in_vsync = 1'b0;
    in_pixel = 8'b101_011_01;
    step(); step();
    checks++;
    if (mode_act !== 2'd3 || q !== 24'h556DB6) begin
      errors++;
      $display("FAIL reserved_mode: got m=%0d q=%h, want m=3 q=556db6", mode_act, q);
    end
  endtask

`ifdef VGA_PALETTE_RAM_EN
  task automatic test_palette();
    set_mode(2'd2);
    wr_en = 1'b1; wr_addr = 8'h10; wr_data = 24'h123456;
    step();
    wr_en = 1'b0; in_pixel = 8'h10;
    step(); step();
    checks++;
    if (q !== 24'h123456 || mode_act !== 2'd2) begin
      errors++;
      $display("FAIL palette_read: got q=%h m=%0d, want q=123456 m=2", q, mode_act);
    end
    wr_en = 1'b1; wr_data = 24'hABCDEF;
    step();
    wr_en = 1'b0;
    step();
    checks++;
    if (q !== 24'h123456) begin
      errors++;
      $display("FAIL palette_read_first: got q=%h, want q=123456", q);
    end
    step();
    checks++;
    if (q !== 24'hABCDEF) begin
      errors++;
      $display("FAIL palette_new_data: got q=%h, want q=abcdef", q);
    end
  endtask
`else
  task automatic test_no_palette();
    wr_en = 1'b1; wr_addr = 8'hE0; wr_data = 24'h123456;
    set_mode(2'd2);
    wr_en = 1'b0;
    checks++;
    if (mode_act !== 2'd2) begin
      errors++;
      $display("FAIL no_ram_mode_act: got %0d, want 2", mode_act);
    end
    in_pixel = 8'hE0;
    step(); step();
    checks++;
    if (q !== 24'h0000FF) begin
      errors++;
      $display("FAIL no_ram_as_true_colour: got q=%h, want q=0000ff", q);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_true_colour();
    test_grayscale_blank();
    test_mode_switch();
`ifdef VGA_PALETTE_RAM_EN
    test_palette();
`else
    test_no_palette();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
